dvga_gain_ramp: RTL and testbench
=================================

# dvga_gain_ramp

Upstream command stage for the DVGA SPI serializer.
- Converts a requested attenuation code and a mute request into the 16-bit DVGA register word the serializer transmits whenever its input word changes.
- Slews the code one LSB at a time, so the amplifier never sees large gain jumps.
- Enforces a minimum spacing between word changes, so every intermediate code is fully shifted out before the next one appears.
- Mute bypasses the ramp and forces maximum attenuation immediately.

## Interface
Parameters:
- `GAIN_W`, 6: attenuation code width. 0 = max gain.
- `MUTE_CODE`, 63: code forced on reset and mute. Must fit in `GAIN_W` bits.
- `REG_ADDR`, 7'h02: DVGA gain register address placed in the word.
- `STEP_TICKS`, 48: minimum `clock_en` ticks between consecutive `data` changes. Must be ≥ 40, which exceeds one full serializer transaction.

Ports:
- `clock` in 1: system clock. One clock only.
- `reset` in 1: synchronous, active-high reset.
- `clock_en` in 1: tick enable, the same enable that drives the serializer. All state advances only on ticks.
- `target` in `GAIN_W`: requested attenuation code. Sampled every tick.
- `mute` in 1: level. While high, output is held at `MUTE_CODE`.
- `data` out 16: word to the serializer, registered. Layout: {1'b0 (write), `REG_ADDR`[6:0], (8-`GAIN_W`) zeros, `cur`}.
- `at_target` out 1: registered. High when `cur == target` and `mute` is low.
- `muted` out 1: registered copy of the mute state.

## Operation
Internal registers:
- `cur` [`GAIN_W`]: current code.
- `pace` [6]: ticks remaining before the next change is allowed.
- `state`: one of MUTED, RAMP, HOLD.

Reset, regardless of `clock_en`:
- `cur` = `MUTE_CODE`, `pace` = `STEP_TICKS`-1, `state` = MUTED.
- `data` = {1'b0, `REG_ADDR`, pad, `MUTE_CODE`} (0x023F with defaults).
- `at_target` = 0, `muted` = 1.

On each tick, priority order:
1. **Mute.** If `mute`: state → MUTED.
   - If `cur != MUTE_CODE`: set `cur` = `MUTE_CODE` at once and reload `pace` = `STEP_TICKS`-1. Mute ignores `pace`.
   - Otherwise `pace` keeps counting down.
2. **MUTED with `mute` low.** State → RAMP. Ramping starts from `MUTE_CODE`; the first step obeys `pace`.
3. **RAMP.**
   - `pace` > 0: decrement `pace`.
   - `pace` == 0 and `cur != target`: move `cur` one LSB toward `target` and reload `pace`. Direction is re-evaluated every step, so a target change mid-ramp reverses or extends the ramp without restarting.
   - `pace` == 0 and `cur == target`: go to HOLD.
4. **HOLD.**
   - `pace` counts down and saturates at 0.
   - Any `target != cur` → RAMP. The first step happens once `pace` == 0, possibly on the same tick.

Arithmetic:
- Steps are ±1 only. Unsigned compare of `cur` and `target`.
- No wrap: the step is never taken past `target`, so codes 0 and 2^`GAIN_W`-1 are safe.
- `data` is a pure repack of `cur`. It changes only when `cur` changes.

## Timing
- Every `data` change is followed by ≥ `STEP_TICKS` ticks without change. The only exception is a mute jump, which may follow a step early.
- Mute latency: `data` = mute word one clock after the first tick with `mute` high.
- Ramp time for a distance of D codes: D·`STEP_TICKS` ticks (±1 tick of initial `pace` residue).
- `at_target` rises on the same edge where `cur` reaches `target`, with `mute` low.
- `mute` deasserted mid-countdown: `pace` is not reset. Otherwise mute glitches would stall the ramp.
- `reset` during a ramp: back to the MUTED reset state on the next edge. Takes effect even when `clock_en` = 0.
- No output moves on clocks without `clock_en`.

## Structure
- Shared package `dvga_pkg`: `REG_ADDR`, `MUTE_CODE`, write-bit constant, and a `dvga_word(code)` packing function. The serializer side and tests reuse these.
- One natural sub-module, `dvga_step_pacer`: `pace` countdown with reload, saturation and a `ready` output. Everything else stays inline.

## Test plan
- **Reset.** Assert `reset` for 3 clocks with `clock_en` = 0 → `data` = 0x023F, `muted` = 1, `at_target` = 0.
- **Ramp down.** Release mute with `target` = 60 → `data` low byte steps 63→62→61→60, with changes exactly 48 ticks apart (first within 48 ticks). `at_target` rises with 60.
- **Reversal.** Ramp 10→20; at `cur` = 14 set `target` = 12 → sequence 14, 13, 12. Never 15. Spacing stays 48 ticks.
- **Mute mid-ramp.** At `cur` = 30 assert `mute` → `data` = 0x023F one clock after that tick. `muted` = 1. Unmute → ramp resumes downward from 63.
- **Hold then change.** Settle at 5, wait 200 ticks, set `target` = 4 → `data` = 0x0204 on the next tick.
- **Boundaries and enable gating.** `target` 0 from `cur` 1 → stops at 0, no wrap. With `clock_en` = 0 for 1000 clocks, `data` stays constant.

Source files
------------

// File: rtl/dvga_pkg.sv
// Shared DVGA register constants and word packing, used by the gain ramp,
// the SPI serializer side and the tests.
package dvga_pkg;

    localparam logic [6:0]  DVGA_REG_ADDR  = 7'h02;
    localparam int unsigned DVGA_MUTE_CODE = 63;
    localparam logic        DVGA_WR_BIT    = 1'b0;

    typedef enum logic [1:0] {
        ST_MUTED,
        ST_RAMP,
        ST_HOLD
    } ramp_state_e;

    // {write bit, 7-bit address, zero-padded 8-bit code}
    function automatic logic [15:0] dvga_word(input logic [7:0] code,
                                              input logic [6:0] addr = DVGA_REG_ADDR);
        return {DVGA_WR_BIT, addr, code};
    endfunction

endpackage

// File: rtl/dvga_step_pacer.sv
// Countdown that spaces gain-word changes: reloads on a change, otherwise
// counts down on each tick and saturates at zero.
module dvga_step_pacer #(
    parameter int STEP_TICKS = 48
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_i,
    input  logic reload_i,
    output logic ready_o
);

    localparam logic [5:0] RELOAD = 6'(STEP_TICKS - 1);

    logic [5:0] pace_q, pace_d;

    always_comb begin
        pace_d = pace_q;
        if (reload_i)
            pace_d = RELOAD;
        else if (pace_q != 6'd0)
            pace_d = pace_q - 6'd1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            pace_q <= RELOAD;
        else if (tick_i)
            pace_q <= pace_d;
    end

    assign ready_o = (pace_q == 6'd0);

endmodule

// File: rtl/dvga_gain_ramp.sv
// DVGA command stage: slews the attenuation code one LSB per pacing interval
// toward the target and packs it into the serializer register word.
module dvga_gain_ramp
    import dvga_pkg::*;
#(
    parameter int          GAIN_W     = 6,
    parameter int unsigned MUTE_CODE  = DVGA_MUTE_CODE,
    parameter logic [6:0]  REG_ADDR   = DVGA_REG_ADDR,
    parameter int          STEP_TICKS = 48
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clock_en,
    input  logic [GAIN_W-1:0] target,
    input  logic              mute,
    output logic [15:0]       data,
    output logic              at_target,
    output logic              muted
);

    localparam logic [GAIN_W-1:0] MUTE_Q = GAIN_W'(MUTE_CODE);

    ramp_state_e       state_q;
    logic [GAIN_W-1:0] cur_q, cur_d;
    logic [15:0]       data_q;
    logic              at_target_q, muted_q;
    logic              ready, reload, need_step;

    // Direction is picked fresh on every step, so target changes mid-ramp
    // simply reverse or extend it.
    assign cur_d     = (target > cur_q) ? cur_q + GAIN_W'(1) : cur_q - GAIN_W'(1);
    assign need_step = (state_q != ST_MUTED) && ready && (cur_q != target);
    assign reload    = clock_en && (mute ? (cur_q != MUTE_Q) : need_step);

    dvga_step_pacer #(.STEP_TICKS(STEP_TICKS)) u_pacer (
        .clock   (clock),
        .reset   (reset),
        .tick_i  (clock_en),
        .reload_i(reload),
        .ready_o (ready)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_MUTED;
            cur_q       <= MUTE_Q;
            data_q      <= dvga_word(8'(MUTE_Q), REG_ADDR);
            at_target_q <= 1'b0;
            muted_q     <= 1'b1;
        end else if (clock_en) begin
            muted_q <= mute;
            if (mute) begin
                state_q     <= ST_MUTED;
                cur_q       <= MUTE_Q;
                data_q      <= dvga_word(8'(MUTE_Q), REG_ADDR);
                at_target_q <= 1'b0;
            end else if (state_q == ST_MUTED) begin
                // First step out of mute still waits for the pacer.
                state_q     <= ST_RAMP;
                at_target_q <= (cur_q == target);
            end else if (cur_q != target) begin
                state_q <= ST_RAMP;
                if (need_step) begin
                    cur_q       <= cur_d;
                    data_q      <= dvga_word(8'(cur_d), REG_ADDR);
                    at_target_q <= (cur_d == target);
                end else begin
                    at_target_q <= 1'b0;
                end
            end else begin
                if (ready)
                    state_q <= ST_HOLD;
                at_target_q <= 1'b1;
            end
        end
    end

    assign data      = data_q;
    assign at_target = at_target_q;
    assign muted     = muted_q;

endmodule

// File: tb/tb_dvga_gain_ramp.sv
// Directed bench for dvga_gain_ramp with hand-computed expected words.
module tb_dvga_gain_ramp;

    logic        clock = 1'b0;
    logic        reset, clock_en, mute;
    logic [5:0]  target;
    logic [15:0] data;
    logic        at_target, muted;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    dvga_gain_ramp dut (
        .clock    (clock),
        .reset    (reset),
        .clock_en (clock_en),
        .target   (target),
        .mute     (mute),
        .data     (data),
        .at_target(at_target),
        .muted    (muted)
    );

    task automatic step_clk(input int k);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Clocks until data changes; -1 if it stays put for the whole bound.
    task automatic wait_change(input int bound, output int n);
        logic [15:0] prev;
        prev = data;
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clock);
            #1;
            if (data !== prev) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_code(input logic [5:0] code, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (data[5:0] === code) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (data[5:0] === code) ok = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clock_en = 1'b0; mute = 1'b1; target = 6'd63;
        step_clk(3);
        n_cmp++; if (data !== 16'h023F) begin n_bad++; $display("FAIL reset_data: got %h want 023f", data); end
        n_cmp++; if (muted !== 1'b1) begin n_bad++; $display("FAIL reset_muted: got %b want 1", muted); end
        n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL reset_at_target: got %b want 0", at_target); end
    endtask

    task automatic test_ramp_down();
        int n;
        logic [15:0] exp_d;
        reset = 1'b0; clock_en = 1'b1; mute = 1'b0; target = 6'd60;
        wait_change(100, n);
        n_cmp++; if (n < 1 || n > 48) begin n_bad++; $display("FAIL down_first_gap: got %0d want 1..48", n); end
        n_cmp++; if (data !== 16'h023E) begin n_bad++; $display("FAIL down_62: got %h want 023e", data); end
        n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL down_at62: got %b want 0", at_target); end
        for (int c = 61; c >= 60; c--) begin
            exp_d = 16'h0200 | 16'(c);
            wait_change(100, n);
            n_cmp++; if (n !== 48) begin n_bad++; $display("FAIL down_gap_%0d: got %0d want 48", c, n); end
            n_cmp++; if (data !== exp_d) begin n_bad++; $display("FAIL down_code_%0d: got %h want %h", c, data, exp_d); end
        end
        n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL down_at60: got %b want 1", at_target); end
    endtask

    task automatic test_reversal();
        int n;
        bit ok;
        logic [15:0] exp_d;
        target = 6'd10;
        wait_code(6'd10, 3000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rev_reach10: got %h want 020a", data); end
        target = 6'd20;
        for (int c = 11; c <= 14; c++) begin
            exp_d = 16'h0200 | 16'(c);
            wait_change(100, n);
            n_cmp++; if (n !== 48 || data !== exp_d) begin
                n_bad++; $display("FAIL rev_up_%0d: gap %0d data %h want 48 %h", c, n, data, exp_d); end
        end
        target = 6'd12;
        for (int c = 13; c >= 12; c--) begin
            exp_d = 16'h0200 | 16'(c);
            wait_change(100, n);
            n_cmp++; if (n !== 48 || data !== exp_d) begin
                n_bad++; $display("FAIL rev_down_%0d: gap %0d data %h want 48 %h", c, n, data, exp_d); end
        end
        wait_change(150, n);
        n_cmp++; if (n !== -1 || data !== 16'h020C) begin
            n_bad++; $display("FAIL rev_settle: change %0d data %h want -1 020c", n, data); end
        n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL rev_at12: got %b want 1", at_target); end
    endtask

    task automatic test_mute_mid_ramp();
        int n;
        bit ok;
        target = 6'd40;
        wait_code(6'd30, 1500, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL mute_reach30: got %h want 021e", data); end
        mute = 1'b1;
        step_clk(1);
        n_cmp++; if (data !== 16'h023F) begin n_bad++; $display("FAIL mute_data: got %h want 023f", data); end
        n_cmp++; if (muted !== 1'b1 || at_target !== 1'b0) begin
            n_bad++; $display("FAIL mute_flags: muted %b at %b want 1 0", muted, at_target); end
        mute = 1'b0; target = 6'd50;
        wait_change(100, n);
        n_cmp++; if (n !== 48 || data !== 16'h023E) begin
            n_bad++; $display("FAIL unmute_resume: gap %0d data %h want 48 023e", n, data); end
        n_cmp++; if (muted !== 1'b0) begin n_bad++; $display("FAIL unmute_muted: got %b want 0", muted); end
    endtask

    task automatic test_hold_change();
        bit ok;
        target = 6'd5;
        wait_code(6'd5, 3500, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL hold_reach5: got %h want 0205", data); end
        step_clk(200);
        n_cmp++; if (data !== 16'h0205 || at_target !== 1'b1) begin
            n_bad++; $display("FAIL hold_steady: data %h at %b want 0205 1", data, at_target); end
        target = 6'd4;
        step_clk(1);
        n_cmp++; if (data !== 16'h0204 || at_target !== 1'b1) begin
            n_bad++; $display("FAIL hold_step: data %h at %b want 0204 1", data, at_target); end
    endtask

    task automatic test_boundaries();
        int n;
        bit ok;
        target = 6'd0;
        wait_code(6'd0, 400, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bnd_reach0: got %h want 0200", data); end
        step_clk(200);
        n_cmp++; if (data !== 16'h0200 || at_target !== 1'b1) begin
            n_bad++; $display("FAIL bnd_zero_hold: data %h at %b want 0200 1", data, at_target); end
        mute = 1'b1;
        step_clk(1);
        mute = 1'b0; target = 6'd63;
        step_clk(1);
        n_cmp++; if (data !== 16'h023F || at_target !== 1'b1 || muted !== 1'b0) begin
            n_bad++; $display("FAIL bnd_top: data %h at %b muted %b want 023f 1 0", data, at_target, muted); end
        wait_change(150, n);
        n_cmp++; if (n !== -1) begin n_bad++; $display("FAIL bnd_top_wrap: change after %0d want -1", n); end
    endtask

    task automatic test_enable_gating();
        int n;
        target = 6'd30; clock_en = 1'b0;
        step_clk(1000);
        n_cmp++; if (data !== 16'h023F || at_target !== 1'b1) begin
            n_bad++; $display("FAIL gate_frozen: data %h at %b want 023f 1", data, at_target); end
        clock_en = 1'b1;
        wait_change(100, n);
        n_cmp++; if (n !== 1 || data !== 16'h023E) begin
            n_bad++; $display("FAIL gate_resume: gap %0d data %h want 1 023e", n, data); end
        clock_en = 1'b0; reset = 1'b1;
        step_clk(1);
        n_cmp++; if (data !== 16'h023F || muted !== 1'b1 || at_target !== 1'b0) begin
            n_bad++; $display("FAIL gate_reset: data %h muted %b at %b want 023f 1 0", data, muted, at_target); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_down();
        test_reversal();
        test_mute_mid_ramp();
        test_hold_change();
        test_boundaries();
        test_enable_gating();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
